// File: rtl/rvv_backend_pkg.sv
// rtl/rvv_backend_pkg.sv - shared reorder-buffer types and default widths
package rvv_backend_pkg;

  localparam int ROB_GEN_DEPTH  = 8;
  localparam int ROB_GEN_INFO_W = 64;
  localparam int ROB_GEN_DATA_W = 128;
  localparam int ROB_GEN_PTR_W  = $clog2(ROB_GEN_DEPTH);
  localparam int ROB_GEN_CNT_W  = $clog2(ROB_GEN_DEPTH + 1);

  // One reorder-buffer slot: status flags plus the uop payload and its result.
  typedef struct packed {
    logic                      valid;
    logic                      done;
    logic                      trap;
    logic                      wvalid;
    logic                      sat;
    logic [ROB_GEN_INFO_W-1:0] info;
    logic [ROB_GEN_DATA_W-1:0] data;
  } ROB_GEN_ENTRY_t;

endpackage

// File: rtl/rvv_backend_rob_gen_ctrl.sv
// rtl/rvv_backend_rob_gen_ctrl.sv - ROB pointers, occupancy, prefix accept/pop and flush
module rvv_backend_rob_gen_ctrl #(
  parameter int  DEPTH  = 8,
  parameter int  NUM_DP = 2,
  parameter int  NUM_RT = 4,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_DP-1:0] dp_valid,
  input  logic              head_trap,
  input  logic [NUM_RT-1:0] rt_valid,
  input  logic [NUM_RT-1:0] rt_ready,
  output logic [NUM_DP-1:0] dp_ready,
  output logic [NUM_DP-1:0] push_en,
  output logic [NUM_RT-1:0] pop_en,
  output logic [PTR_W-1:0]  wptr,
  output logic [PTR_W-1:0]  rptr,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              flush
);

  int               free_slots;
  logic             push_chain;
  logic             pop_chain;
  logic [CNT_W-1:0] n_push;
  logic [CNT_W-1:0] n_pop;

  // Free space is taken from the registered count, so retires this cycle never make room for pushes.
  always_comb begin
    free_slots = DEPTH - int'(count);
    dp_ready   = '0;
    push_en    = '0;
    pop_en     = '0;
    n_push     = '0;
    n_pop      = '0;
    push_chain = 1'b1;
    pop_chain  = 1'b1;
    for (int k = 0; k < NUM_DP; k++) begin
      dp_ready[k] = (free_slots > k) && !head_trap;
      push_chain  = push_chain & dp_valid[k] & dp_ready[k];
      push_en[k]  = push_chain;
      if (push_chain) n_push = n_push + CNT_W'(1);
    end
    for (int k = 0; k < NUM_RT; k++) begin
      pop_chain = pop_chain & rt_valid[k] & rt_ready[k];
      pop_en[k] = pop_chain;
      if (pop_chain) n_pop = n_pop + CNT_W'(1);
    end
    flush = pop_en[0] & head_trap;
    empty = (count == '0);
  end

  // Pointers wrap naturally because DEPTH is a power of two; a flush rewinds everything to zero.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PTR_W'(n_push);
      rptr  <= rptr + PTR_W'(n_pop);
      count <= count + n_push - n_pop;
    end
  end

endmodule

// File: rtl/rvv_backend_rob_gen.sv
// rtl/rvv_backend_rob_gen.sv - parametrised vector reorder buffer with writeback merge and flush
module rvv_backend_rob_gen
  import rvv_backend_pkg::*;
#(
  parameter int  DEPTH  = ROB_GEN_DEPTH,
  parameter int  NUM_DP = 2,
  parameter int  NUM_RT = 4,
  parameter int  NUM_WB = 9,
  parameter int  INFO_W = ROB_GEN_INFO_W,
  parameter int  DATA_W = ROB_GEN_DATA_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_DP-1:0]        dp_valid,
  input  logic [NUM_DP*INFO_W-1:0] dp_info,
  output logic [NUM_DP-1:0]        dp_ready,
  output logic [PTR_W-1:0]         dp_index,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PTR_W-1:0]  wb_entry,
  input  logic [NUM_WB-1:0]        wb_wvalid,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic [NUM_WB-1:0]        wb_sat,
  output logic                     wb_err,
  output logic [NUM_RT-1:0]        rt_valid,
  input  logic [NUM_RT-1:0]        rt_ready,
  output logic [NUM_RT*INFO_W-1:0] rt_info,
  output logic [NUM_RT*DATA_W-1:0] rt_data,
  output logic [NUM_RT-1:0]        rt_wvalid,
  output logic [NUM_RT-1:0]        rt_sat,
  output logic [NUM_RT-1:0]        rt_trap,
  input  logic                     trap_valid,
  input  logic [PTR_W-1:0]         trap_entry,
  output logic                     flush,
  output logic [CNT_W-1:0]         count,
  output logic                     empty
);

  ROB_GEN_ENTRY_t rob     [DEPTH];
  ROB_GEN_ENTRY_t rob_clr [DEPTH];
  ROB_GEN_ENTRY_t rob_nxt [DEPTH];

  logic [PTR_W-1:0]  wptr;
  logic [PTR_W-1:0]  rptr;
  logic [NUM_DP-1:0] push_en;
  logic [NUM_RT-1:0] pop_en;
  logic              head_trap;
  logic [PTR_W-1:0]  lane_idx;
  logic              lane_chain;
  logic              prev_trap;
  logic              wb_err_nxt;
  logic [PTR_W-1:0]  wb_e;

  rvv_backend_rob_gen_ctrl #(
    .DEPTH  (DEPTH),
    .NUM_DP (NUM_DP),
    .NUM_RT (NUM_RT)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .dp_valid  (dp_valid),
    .head_trap (head_trap),
    .rt_valid  (rt_valid),
    .rt_ready  (rt_ready),
    .dp_ready  (dp_ready),
    .push_en   (push_en),
    .pop_en    (pop_en),
    .wptr      (wptr),
    .rptr      (rptr),
    .count     (count),
    .empty     (empty),
    .flush     (flush)
  );

  assign dp_index  = wptr;
  assign head_trap = rob[rptr].valid & rob[rptr].trap;

  // Retire lanes: lane 0 may leave on done or trap; later lanes need an unbroken run of done, trap-free entries.
  always_comb begin
    rt_valid   = '0;
    rt_info    = '0;
    rt_data    = '0;
    rt_wvalid  = '0;
    rt_sat     = '0;
    rt_trap    = '0;
    lane_idx   = '0;
    lane_chain = 1'b1;
    prev_trap  = 1'b0;
    for (int k = 0; k < NUM_RT; k++) begin
      lane_idx = rptr + PTR_W'(k);
      if (k == 0) begin
        lane_chain = rob[lane_idx].valid & (rob[lane_idx].done | rob[lane_idx].trap);
      end else begin
        lane_chain = lane_chain & rob[lane_idx].valid & rob[lane_idx].done & ~prev_trap & ~rob[lane_idx].trap;
      end
      prev_trap                     = rob[lane_idx].trap;
      rt_valid[k]                   = lane_chain;
      rt_info[k*INFO_W +: INFO_W]   = rob[lane_idx].info;
      rt_data[k*DATA_W +: DATA_W]   = rob[lane_idx].data;
      rt_wvalid[k]                  = rob[lane_idx].wvalid & rob[lane_idx].done;
      rt_sat[k]                     = rob[lane_idx].sat;
      rt_trap[k]                    = rob[lane_idx].trap;
    end
  end

  // Flag an error for writebacks to empty slots or two ports landing on one slot in the same cycle.
  always_comb begin
    wb_err_nxt = 1'b0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p]) begin
        if (!rob[wb_entry[p*PTR_W +: PTR_W]].valid) wb_err_nxt = 1'b1;
        for (int q = p + 1; q < NUM_WB; q++) begin
          if (wb_valid[q] && (wb_entry[q*PTR_W +: PTR_W] == wb_entry[p*PTR_W +: PTR_W])) wb_err_nxt = 1'b1;
        end
      end
    end
  end

  // Copy of storage with all status flags dropped, shared by reset and flush.
  always_comb begin
    rob_clr = rob;
    for (int i = 0; i < DEPTH; i++) begin
      rob_clr[i].valid = 1'b0;
      rob_clr[i].done  = 1'b0;
      rob_clr[i].trap  = 1'b0;
    end
  end

  // Next storage state: writebacks in ascending port order so the highest port wins, then traps, pops, pushes.
  always_comb begin
    rob_nxt = rob;
    wb_e    = '0;
    if (flush) begin
      rob_nxt = rob_clr;
    end else begin
      for (int p = 0; p < NUM_WB; p++) begin
        wb_e = wb_entry[p*PTR_W +: PTR_W];
        if (wb_valid[p] && rob[wb_e].valid) begin
          rob_nxt[wb_e].done   = 1'b1;
          rob_nxt[wb_e].wvalid = wb_wvalid[p];
          rob_nxt[wb_e].data   = wb_data[p*DATA_W +: DATA_W];
          rob_nxt[wb_e].sat    = wb_sat[p];
        end
      end
      if (trap_valid && rob[trap_entry].valid) rob_nxt[trap_entry].trap = 1'b1;
      for (int k = 0; k < NUM_RT; k++) begin
        if (pop_en[k]) begin
          rob_nxt[rptr + PTR_W'(k)].valid = 1'b0;
          rob_nxt[rptr + PTR_W'(k)].done  = 1'b0;
          rob_nxt[rptr + PTR_W'(k)].trap  = 1'b0;
        end
      end
      for (int k = 0; k < NUM_DP; k++) begin
        if (push_en[k]) begin
          rob_nxt[wptr + PTR_W'(k)].valid  = 1'b1;
          rob_nxt[wptr + PTR_W'(k)].done   = 1'b0;
          rob_nxt[wptr + PTR_W'(k)].trap   = 1'b0;
          rob_nxt[wptr + PTR_W'(k)].wvalid = 1'b0;
          rob_nxt[wptr + PTR_W'(k)].info   = dp_info[k*INFO_W +: INFO_W];
        end
      end
    end
  end

  // Entry storage register; reset only needs to drop the status flags.
  always_ff @(posedge clk) begin
    if (rst) rob <= rob_clr;
    else     rob <= rob_nxt;
  end

  // Writeback error is reported one cycle after the offending writes.
  always_ff @(posedge clk) begin
    if (rst) wb_err <= 1'b0;
    else     wb_err <= wb_err_nxt;
  end

endmodule

// File: tb/tb_rvv_backend_rob_gen.sv
// tb/tb_rvv_backend_rob_gen.sv - self-checking bench for rvv_backend_rob_gen
module tb_rvv_backend_rob_gen;

  localparam int DEPTH  = 8;
  localparam int NUM_DP = 2;
  localparam int NUM_RT = 4;
  localparam int NUM_WB = 9;
  localparam int INFO_W = 64;
  localparam int DATA_W = 128;
  localparam int PTR_W  = 3;
  localparam int CNT_W  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic [NUM_DP-1:0]        dp_valid;
  logic [NUM_DP*INFO_W-1:0] dp_info;
  logic [NUM_DP-1:0]        dp_ready;
  logic [PTR_W-1:0]         dp_index;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*PTR_W-1:0]  wb_entry;
  logic [NUM_WB-1:0]        wb_wvalid;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [NUM_WB-1:0]        wb_sat;
  logic                     wb_err;
  logic [NUM_RT-1:0]        rt_valid;
  logic [NUM_RT-1:0]        rt_ready;
  logic [NUM_RT*INFO_W-1:0] rt_info;
  logic [NUM_RT*DATA_W-1:0] rt_data;
  logic [NUM_RT-1:0]        rt_wvalid;
  logic [NUM_RT-1:0]        rt_sat;
  logic [NUM_RT-1:0]        rt_trap;
  logic                     trap_valid;
  logic [PTR_W-1:0]         trap_entry;
  logic                     flush;
  logic [CNT_W-1:0]         count;
  logic                     empty;

  rvv_backend_rob_gen #(
    .DEPTH(DEPTH), .NUM_DP(NUM_DP), .NUM_RT(NUM_RT), .NUM_WB(NUM_WB), .INFO_W(INFO_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst(rst),
    .dp_valid(dp_valid), .dp_info(dp_info), .dp_ready(dp_ready), .dp_index(dp_index),
    .wb_valid(wb_valid), .wb_entry(wb_entry), .wb_wvalid(wb_wvalid), .wb_data(wb_data), .wb_sat(wb_sat),
    .wb_err(wb_err),
    .rt_valid(rt_valid), .rt_ready(rt_ready), .rt_info(rt_info), .rt_data(rt_data),
    .rt_wvalid(rt_wvalid), .rt_sat(rt_sat), .rt_trap(rt_trap),
    .trap_valid(trap_valid), .trap_entry(trap_entry),
    .flush(flush), .count(count), .empty(empty)
  );

  // Reference model: the buffer is an in-order list of uops, head first.
  typedef struct {
    int                idx;
    logic [INFO_W-1:0] info;
    bit                done;
    bit                trap;
    bit                wv;
    bit                sat;
    logic [DATA_W-1:0] data;
  } uop_t;

  uop_t mq[$];
  int   m_wptr;
  bit   m_wb_err;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [DATA_W-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int find(int e);
    for (int i = 0; i < mq.size(); i++) if (mq[i].idx == e) return i;
    return -1;
  endfunction

  function automatic logic [NUM_DP-1:0] m_dp_ready();
    logic [NUM_DP-1:0] r;
    bit ht;
    r  = '0;
    ht = (mq.size() > 0) && mq[0].trap;
    for (int k = 0; k < NUM_DP; k++) r[k] = !ht && ((DEPTH - mq.size()) > k);
    return r;
  endfunction

  function automatic logic [NUM_RT-1:0] m_rt_valid();
    logic [NUM_RT-1:0] r;
    bit ok;
    r = '0;
    if (mq.size() > 0 && (mq[0].done || mq[0].trap)) r[0] = 1'b1;
    for (int k = 1; k < NUM_RT; k++) begin
      ok = (k < mq.size());
      if (ok) for (int j = 0; j <= k; j++) if (!mq[j].done || mq[j].trap) ok = 0;
      r[k] = ok;
    end
    return r;
  endfunction

  function automatic int m_pops();
    logic [NUM_RT-1:0] rv;
    int n;
    rv = m_rt_valid();
    n  = 0;
    for (int k = 0; k < NUM_RT; k++) if (n == k && rv[k] && rt_ready[k]) n++;
    return n;
  endfunction

  task automatic idle();
    dp_valid = '0; dp_info = '0;
    wb_valid = '0; wb_entry = '0; wb_wvalid = '0; wb_data = '0; wb_sat = '0;
    rt_ready = '0; trap_valid = 1'b0; trap_entry = '0;
  endtask

  task automatic set_wb(input int p, input int e, input logic [DATA_W-1:0] d, input bit wv, input bit s);
    wb_valid[p]                 = 1'b1;
    wb_entry[p*PTR_W +: PTR_W]  = PTR_W'(e);
    wb_data[p*DATA_W +: DATA_W] = d;
    wb_wvalid[p]                = wv;
    wb_sat[p]                   = s;
  endtask

  // Advance one clock, applying the same inputs to the model.
  task automatic cycle();
    logic [NUM_DP-1:0] rdy;
    int npop, pos, e;
    bit fl, err, chain;
    int hits[DEPTH];
    uop_t t;
    rdy  = m_dp_ready();
    npop = m_pops();
    fl   = (npop > 0) && mq[0].trap;
    err  = 0;
    for (int i = 0; i < DEPTH; i++) hits[i] = 0;
    for (int p = 0; p < NUM_WB; p++) begin
      if (wb_valid[p]) begin
        e = int'(wb_entry[p*PTR_W +: PTR_W]);
        hits[e]++;
        pos = find(e);
        if (pos < 0) err = 1;
        else begin
          t = mq[pos];
          t.done = 1; t.wv = wb_wvalid[p]; t.sat = wb_sat[p]; t.data = wb_data[p*DATA_W +: DATA_W];
          mq[pos] = t;
        end
      end
    end
    for (int i = 0; i < DEPTH; i++) if (hits[i] > 1) err = 1;
    if (trap_valid) begin
      pos = find(int'(trap_entry));
      if (pos >= 0) begin t = mq[pos]; t.trap = 1; mq[pos] = t; end
    end
    if (fl) begin
      mq.delete();
      m_wptr = 0;
    end else begin
      repeat (npop) void'(mq.pop_front());
      chain = 1;
      for (int k = 0; k < NUM_DP; k++) begin
        chain = chain && dp_valid[k] && rdy[k];
        if (chain) begin
          t.idx = m_wptr; t.info = dp_info[k*INFO_W +: INFO_W];
          t.done = 0; t.trap = 0; t.wv = 0; t.sat = 0; t.data = '0;
          mq.push_back(t);
          m_wptr = (m_wptr + 1) % DEPTH;
        end
      end
    end
    @(posedge clk);
    #1;
    m_wb_err = err;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_wptr   = 0;
    m_wb_err = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (dp_ready !== 2'b11) begin errors++; $display("FAIL reset_dp_ready got %b exp 11", dp_ready); end
    checks++; if (rt_valid !== 4'b0000) begin errors++; $display("FAIL reset_rt_valid got %b exp 0000", rt_valid); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush got %b exp 0", flush); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got %b exp 0", wb_err); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (dp_index !== 3'd0) begin errors++; $display("FAIL reset_dp_index got %0d exp 0", dp_index); end
  endtask

  task automatic test_dispatch_fill();
    do_reset();
    dp_valid = 2'b11; dp_info = rand128(); #1;
    checks++; if (dp_index !== 3'd0) begin errors++; $display("FAIL disp_index0 got %0d exp 0", dp_index); end
    cycle();
    checks++; if (dp_index !== 3'd2) begin errors++; $display("FAIL disp_index1 got %0d exp 2", dp_index); end
    dp_info = rand128();
    cycle();
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL disp_count4 got %0d exp 4", count); end
    checks++; if (empty !== 1'b0) begin errors++; $display("FAIL disp_empty got %b exp 0", empty); end
    dp_info = rand128(); cycle();
    dp_info = rand128(); cycle();
    idle(); #1;
    checks++; if (count !== 4'd8) begin errors++; $display("FAIL fill_count got %0d exp 8", count); end
    checks++; if (dp_ready !== 2'b00) begin errors++; $display("FAIL fill_dp_ready got %b exp 00", dp_ready); end
    set_wb(0, 0, rand128(), 1, 0);
    set_wb(1, 1, rand128(), 0, 0);
    cycle();
    idle();
    rt_ready = 4'b0011; dp_valid = 2'b11; dp_info = rand128(); #1;
    checks++; if (rt_valid !== 4'b0011) begin errors++; $display("FAIL full_rt_valid got %b exp 0011", rt_valid); end
    checks++; if (dp_ready !== 2'b00) begin errors++; $display("FAIL full_dp_ready got %b exp 00", dp_ready); end
    cycle();
    idle(); #1;
    checks++; if (count !== 4'd6) begin errors++; $display("FAIL full_retire_count got %0d exp 6", count); end
  endtask

  task automatic test_ooo_writeback();
    int order[4] = '{3, 1, 0, 2};
    logic [3:0] expv[4] = '{4'b0000, 4'b0000, 4'b0011, 4'b1111};
    logic [DATA_W-1:0] wd[4];
    logic [INFO_W-1:0] wi[4];
    do_reset();
    dp_valid = 2'b11; dp_info = rand128();
    wi[0] = dp_info[0 +: INFO_W]; wi[1] = dp_info[INFO_W +: INFO_W];
    cycle();
    dp_info = rand128();
    wi[2] = dp_info[0 +: INFO_W]; wi[3] = dp_info[INFO_W +: INFO_W];
    cycle();
    for (int i = 0; i < 4; i++) begin
      idle();
      wd[order[i]] = rand128();
      set_wb(i + 3, order[i], wd[order[i]], 1, 0);
      cycle();
      idle(); #1;
      checks++; if (rt_valid !== expv[i]) begin errors++; $display("FAIL ooo_rt_valid step %0d got %b exp %b", i, rt_valid, expv[i]); end
    end
    rt_ready = 4'b1111; #1;
    for (int k = 0; k < 4; k++) begin
      checks++; if (rt_data[k*DATA_W +: DATA_W] !== wd[k]) begin errors++; $display("FAIL ooo_data lane %0d got %h exp %h", k, rt_data[k*DATA_W +: DATA_W], wd[k]); end
      checks++; if (rt_info[k*INFO_W +: INFO_W] !== wi[k]) begin errors++; $display("FAIL ooo_info lane %0d got %h exp %h", k, rt_info[k*INFO_W +: INFO_W], wi[k]); end
    end
    cycle();
    idle(); #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL ooo_drain count %0d empty %b exp 0 1", count, empty); end
  endtask

  task automatic test_wb_collision();
    logic [DATA_W-1:0] d2, d5;
    do_reset();
    dp_valid = 2'b11; dp_info = rand128();
    cycle();
    idle();
    d2 = rand128(); d5 = rand128();
    set_wb(0, 0, rand128(), 1, 0);
    set_wb(2, 1, d2, 0, 0);
    set_wb(5, 1, d5, 1, 1);
    cycle();
    idle(); #1;
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL coll_wb_err got %b exp 1", wb_err); end
    checks++; if (rt_valid !== 4'b0011) begin errors++; $display("FAIL coll_rt_valid got %b exp 0011", rt_valid); end
    checks++; if (rt_data[DATA_W +: DATA_W] !== d5) begin errors++; $display("FAIL coll_data got %h exp %h", rt_data[DATA_W +: DATA_W], d5); end
    checks++; if (rt_sat[1] !== 1'b1 || rt_wvalid[1] !== 1'b1) begin errors++; $display("FAIL coll_flags sat %b wvalid %b exp 1 1", rt_sat[1], rt_wvalid[1]); end
    set_wb(3, 5, rand128(), 1, 0);
    cycle();
    idle(); #1;
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL empty_wb_err got %b exp 1", wb_err); end
    checks++; if (count !== 4'd2 || rt_valid !== 4'b0011) begin errors++; $display("FAIL empty_wb_state count %0d rt_valid %b exp 2 0011", count, rt_valid); end
    cycle();
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL wb_err_clear got %b exp 0", wb_err); end
  endtask

  task automatic test_trap_flush();
    do_reset();
    dp_valid = 2'b11; dp_info = rand128(); cycle();
    dp_info = rand128(); cycle();
    dp_valid = 2'b01; dp_info = rand128(); cycle();
    idle();
    for (int i = 0; i < 5; i++) set_wb(i, i, rand128(), 1, 0);
    cycle();
    idle();
    trap_valid = 1'b1; trap_entry = 3'd2;
    cycle();
    idle(); #1;
    checks++; if (rt_valid !== 4'b0011) begin errors++; $display("FAIL trap_pre_rt_valid got %b exp 0011", rt_valid); end
    rt_ready = 4'b1111; #1;
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL trap_early_flush got %b exp 0", flush); end
    cycle();
    idle(); #1;
    checks++; if (rt_valid !== 4'b0001 || rt_trap[0] !== 1'b1) begin errors++; $display("FAIL trap_head rt_valid %b rt_trap0 %b exp 0001 1", rt_valid, rt_trap[0]); end
    checks++; if (dp_ready !== 2'b00 || count !== 4'd3) begin errors++; $display("FAIL trap_head_state dp_ready %b count %0d exp 00 3", dp_ready, count); end
    rt_ready = 4'b0001; #1;
    checks++; if (flush !== 1'b1) begin errors++; $display("FAIL trap_flush got %b exp 1", flush); end
    cycle();
    idle(); #1;
    checks++; if (count !== 4'd0 || dp_index !== 3'd0 || empty !== 1'b1) begin errors++; $display("FAIL post_flush count %0d dp_index %0d empty %b exp 0 0 1", count, dp_index, empty); end
    trap_valid = 1'b1; trap_entry = 3'd3;
    cycle();
    idle(); #1;
    checks++; if (wb_err !== 1'b0 || rt_valid !== 4'b0000) begin errors++; $display("FAIL trap_invalid wb_err %b rt_valid %b exp 0 0000", wb_err, rt_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    dp_valid = 2'b11; dp_info = rand128(); cycle();
    idle(); set_wb(0, 0, rand128(), 1, 0); cycle();
    do_reset(); #1;
    checks++; if (count !== 4'd0 || rt_valid !== 4'b0000 || dp_index !== 3'd0) begin errors++; $display("FAIL reset_mid count %0d rt_valid %b dp_index %0d exp 0 0000 0", count, rt_valid, dp_index); end
  endtask

  task automatic test_random(input int n, input bit traps);
    logic [NUM_DP-1:0] er;
    logic [NUM_RT-1:0] ev;
    bit ef;
    int e;
    do_reset();
    for (int c = 0; c < n; c++) begin
      idle();
      dp_valid = NUM_DP'($urandom);
      dp_info  = rand128();
      rt_ready = ($urandom_range(0, 3) == 0) ? NUM_RT'($urandom) : '1;
      for (int p = 0; p < NUM_WB; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          if (mq.size() > 0 && $urandom_range(0, 7) != 0) e = mq[$urandom_range(0, mq.size() - 1)].idx;
          else e = $urandom_range(0, DEPTH - 1);
          set_wb(p, e, rand128(), 1'($urandom), 1'($urandom));
        end
      end
      if (traps && mq.size() > 0 && $urandom_range(0, 15) == 0) begin
        trap_valid = 1'b1;
        trap_entry = PTR_W'(mq[$urandom_range(0, mq.size() - 1)].idx);
      end
      #1;
      er = m_dp_ready();
      ev = m_rt_valid();
      ef = (m_pops() > 0) && mq[0].trap;
      checks++; if (dp_ready !== er) begin errors++; $display("FAIL rnd_dp_ready cyc %0d got %b exp %b", c, dp_ready, er); end
      checks++; if (rt_valid !== ev) begin errors++; $display("FAIL rnd_rt_valid cyc %0d got %b exp %b", c, rt_valid, ev); end
      checks++; if (flush !== ef) begin errors++; $display("FAIL rnd_flush cyc %0d got %b exp %b", c, flush, ef); end
      checks++; if (int'(count) != mq.size() || count > 4'd8) begin errors++; $display("FAIL rnd_count cyc %0d got %0d exp %0d", c, count, mq.size()); end
      checks++; if (int'(dp_index) != m_wptr) begin errors++; $display("FAIL rnd_dp_index cyc %0d got %0d exp %0d", c, dp_index, m_wptr); end
      checks++; if (empty !== (mq.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc %0d got %b", c, empty); end
      checks++; if (wb_err !== m_wb_err) begin errors++; $display("FAIL rnd_wb_err cyc %0d got %b exp %b", c, wb_err, m_wb_err); end
      for (int k = 0; k < NUM_RT; k++) begin
        if (ev[k]) begin
          checks++; if (rt_info[k*INFO_W +: INFO_W] !== mq[k].info) begin errors++; $display("FAIL rnd_info cyc %0d lane %0d got %h exp %h", c, k, rt_info[k*INFO_W +: INFO_W], mq[k].info); end
          checks++; if (rt_trap[k] !== mq[k].trap || rt_wvalid[k] !== (mq[k].wv && mq[k].done)) begin errors++; $display("FAIL rnd_flags cyc %0d lane %0d trap %b wvalid %b exp %b %b", c, k, rt_trap[k], rt_wvalid[k], mq[k].trap, mq[k].wv && mq[k].done); end
          if (mq[k].done) begin
            checks++; if (rt_data[k*DATA_W +: DATA_W] !== mq[k].data || rt_sat[k] !== mq[k].sat) begin errors++; $display("FAIL rnd_data cyc %0d lane %0d got %h/%b exp %h/%b", c, k, rt_data[k*DATA_W +: DATA_W], rt_sat[k], mq[k].data, mq[k].sat); end
          end
        end
      end
      cycle();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_dispatch_fill();
    test_ooo_writeback();
    test_wb_collision();
    test_trap_flush();
    test_reset_mid();
    test_random(20, 1'b0);
    test_random(400, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rvv_backend_rob_gen.md
# rvv_backend_rob_gen

Parametrised successor to the backend reorder buffer: holds up to DEPTH vector uops in program order, collects out-of-order results from NUM_WB processing-unit writeback ports, and retires up to NUM_RT completed uops per cycle to the retire unit. It adds an occupancy counter, registered writeback-error reporting and a flush handshake that cannot race new dispatches. It sits between Dispatch/PUs and the retire unit.

## Interface
- DEPTH, 8: entries; power of two, ≥ NUM_DP and ≥ NUM_RT.
- NUM_DP, 2: dispatch lanes.
- NUM_RT, 4: retire lanes.
- NUM_WB, 9: writeback ports.
- INFO_W, 64: opaque uop info width (w_index, w_type, byte_type, csr).
- DATA_W, 128: result data width.
- Clocking: one clock; reset is synchronous and active-high.
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- dp_valid  in  NUM_DP  dispatch lane valid.
- dp_info  in  NUM_DP×INFO_W  uop info.
- dp_ready  out  NUM_DP  lane k ready.
- dp_index  out  log2(DEPTH)  entry that lane 0 will occupy (wptr).
- wb_valid  in  NUM_WB  result valid.
- wb_entry  in  NUM_WB×log2(DEPTH)  target entry.
- wb_wvalid  in  NUM_WB  result writes VRF.
- wb_data  in  NUM_WB×DATA_W  result.
- wb_sat  in  NUM_WB  vxsat flag.
- wb_err  out  1  registered error pulse.
- rt_valid  out  NUM_RT  retire lane valid.
- rt_ready  in  NUM_RT  retire lane ready.
- rt_info, rt_data, rt_wvalid, rt_sat, rt_trap  out  per-lane  head+k fields.
- trap_valid  in  1  trap report.
- trap_entry  in  log2(DEPTH)  trapping entry.
- flush  out  1  flush pulse to RVS/RVV.
- count  out  log2(DEPTH+1)  occupied entries.
- empty  out  1  count==0.

## Operation
- State per entry: valid, done, trap, info, wvalid, data, sat. Pointers wptr/rptr wrap mod DEPTH; count is tracked separately, so full = (count==DEPTH).
- Dispatch: dp_ready[k] = (DEPTH−count > k) and no head trap. Lane k is accepted only if lanes 0..k−1 are accepted, so pushes are always a prefix. The accepted lanes write entries wptr+k, set valid, clear done and trap, and advance wptr by the number accepted. Free slots are sampled at the start of the cycle, so same-cycle retires do not free space for pushes.
- Writeback: no backpressure. Each port sets done and stores wvalid/data/sat.
  - A write to a non-valid entry is dropped.
  - When two ports hit the same entry in one cycle, the highest port index wins.
  - Either case makes wb_err pulse in the next cycle.
- Trap: trap_valid to a valid entry sets trap; trap_valid to an invalid entry is ignored and raises no error. A trap entry may retire at lane 0 only, done or not. rt_trap=1 on that lane, and rt_wvalid = wvalid & done.
- Retire:
  - rt_valid[0] = head valid & (done | trap).
  - rt_valid[k>0] = entry valid & done & rt_valid[k−1] & ~trap[head+k−1] & ~trap[head+k].
  - rt_valid never depends on rt_ready.
  - pop count = number of leading lanes with valid&ready. Popped entries clear valid and done, and rptr advances by pop count.
- Flush: when lane 0 pops a trap entry, flush=1 combinationally that cycle. At the edge, all valid/done/trap bits clear, wptr=rptr=0, count=0, and any same-cycle writebacks are dropped. No pushes collide because dp_ready is low whenever the head is a trap.

## Timing
- After reset: dp_ready all 1, rt_valid 0, flush 0, wb_err 0, count 0, empty 1, dp_index 0.
- Reset mid-operation discards all entries.
- Push at edge N → entry valid from N+1. Writeback at edge M → retirable from cycle M+1. Minimum dispatch-to-retire is 2 cycles.
- count updates each edge as count + pushes − pops (or 0 on flush).
- Simultaneous full push and full retire: count unchanged and pointers wrap correctly.
- A trap on a non-head entry stays latched until that entry reaches the head.

## Structure
- Shared package rvv_backend_pkg: ROB_GEN_ENTRY_t (valid/done/trap/info/data), pointer and count width localparams.
- One sub-module, rvv_backend_rob_gen_ctrl: pointers, count, prefix-accept/prefix-pop logic and flush. Entry storage and the writeback merge stay in the top level.

## Test plan
- Reset then 4 uops over 2 cycles with DEPTH=8 → dp_index 0,2; count 4; empty 0.
- Fill to 8 → dp_ready=00. Retire 2 and push 2 in the same cycle → push rejected, count 6 next cycle.
- Writebacks out of order to entries 3,1,0,2 → retire lanes 0–3 valid only once all four are done, popping in order 0..3 in one cycle with data matching.
- Ports 2 and 5 hit entry 1 in the same cycle → port 5 data retained, wb_err=1 next cycle. A write to an empty entry is dropped and wb_err pulses.
- Trap on entry 2 with entries 0–4 done → lanes 0–1 retire; the next cycle lane 0 shows entry 2 with rt_trap=1 and lane 1 invalid; on ready, flush=1, then count 0 and wptr 0.
- Wrap-around: 20 push/retire iterations with DEPTH=8 → pointers wrap, order preserved, count never exceeds 8.
